// File: rtl/lsu.sv
// Load/store unit: turns one execute-stage load or store into a single word-aligned
// data-memory transaction, formats store lanes and load results, and stalls the pipe.
module lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_res_i,
  input  logic [31:0] store_data_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] load_data_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        misaligned_o,
  output logic        bus_err_o,
  output logic [1:0]  dbg_state_o
);

  // Counter only has to reach TIMEOUT-1, the last ACCESS cycle before giving up.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    addr_lo_q;
  logic [2:0]    f3_q;
  logic          we_q;

  logic          is_store;
  logic          is_load;
  logic          req_any;
  logic          legal;
  logic          aligned;
  logic          valid;
  logic [3:0]    be_new;
  logic [31:0]   wdata_new;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_fmt;

  // Request decode; a store wins when both request lines are high.
  always_comb begin
    is_store = mem_write_i;
    is_load  = mem_read_i & ~mem_write_i;
    req_any  = mem_read_i | mem_write_i;
    legal    = 1'b0;
    if (is_store) begin
      legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010);
    end else if (is_load) begin
      legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
              (funct3_i == 3'b100) || (funct3_i == 3'b101);
    end
  end

  always_comb begin
    aligned = 1'b1;
    case (funct3_i[1:0])
      2'b01:   aligned = ~alu_res_i[0];
      2'b10:   aligned = (alu_res_i[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign valid = req_any & legal & aligned;

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_new    = 4'b0001 << alu_res_i[1:0];
        wdata_new = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << {alu_res_i[1], 1'b0};
        wdata_new = {2{store_data_i[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = store_data_i;
      end
    endcase
  end

  // Lane select for loads uses the latched offset, not the live ALU result.
  always_comb begin
    rd_byte = dmem_rdata_i[7:0];
    case (addr_lo_q)
      2'b00:   rd_byte = dmem_rdata_i[7:0];
      2'b01:   rd_byte = dmem_rdata_i[15:8];
      2'b10:   rd_byte = dmem_rdata_i[23:16];
      default: rd_byte = dmem_rdata_i[31:24];
    endcase
    rd_half = addr_lo_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
  end

  always_comb begin
    load_fmt = dmem_rdata_i;
    case (f3_q)
      3'b000:  load_fmt = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_fmt = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_fmt = {24'b0, rd_byte};
      3'b101:  load_fmt = {16'b0, rd_half};
      default: load_fmt = dmem_rdata_i;
    endcase
  end

  assign misaligned_o = (state == IDLE) & req_any & legal & ~aligned;
  assign stall_o      = ((state == IDLE) & valid) | (state == ACCESS);
  assign dmem_we_o    = dmem_req_o & we_q;
  assign dbg_state_o  = state;

  // Bus handshake: dmem_req_o rises on entry to ACCESS and holds addr/we/wdata/be
  // stable; the transfer completes on the first cycle with dmem_req_o & dmem_ack_i,
  // after which dmem_req_o drops. An ack seen while dmem_req_o is low is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_lo_q    <= 2'b00;
      f3_q         <= 3'b000;
      we_q         <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_addr_o  <= 32'b0;
      dmem_wdata_o <= 32'b0;
      dmem_be_o    <= 4'b0;
      load_data_o  <= 32'b0;
      done_o       <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o    <= 1'b0;
          bus_err_o <= 1'b0;
          if (valid) begin
            dmem_addr_o  <= {alu_res_i[31:2], 2'b00};
            addr_lo_q    <= alu_res_i[1:0];
            dmem_wdata_o <= wdata_new;
            dmem_be_o    <= be_new;
            f3_q         <= funct3_i;
            we_q         <= is_store;
            dmem_req_o   <= 1'b1;
            cnt          <= '0;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          if (dmem_req_o && dmem_ack_i) begin
            if (!we_q) begin
              load_data_o <= load_fmt;
            end
            dmem_req_o <= 1'b0;
            done_o     <= 1'b1;
            state      <= DONE;
          end else if (cnt == CNT_LAST) begin
            if (!we_q) begin
              load_data_o <= 32'b0;
            end
            dmem_req_o <= 1'b0;
            done_o     <= 1'b1;
            bus_err_o  <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done_o    <= 1'b0;
          bus_err_o <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          dmem_req_o <= 1'b0;
          done_o     <= 1'b0;
          bus_err_o  <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed cases for the documented scenarios plus randomized
// legal accesses, with expected load results queued at drive time.
module tb_lsu;

  localparam int TB_TIMEOUT = 8;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_res_i;
  logic [31:0] store_data_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [2:0]  funct3_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] load_data_o;
  logic        stall_o;
  logic        done_o;
  logic        misaligned_o;
  logic        bus_err_o;
  logic [1:0]  dbg_state_o;

  lsu #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_res_i    (alu_res_i),
    .store_data_i (store_data_i),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .funct3_i     (funct3_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .load_data_o  (load_data_o),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .misaligned_o (misaligned_o),
    .bus_err_o    (bus_err_o),
    .dbg_state_o  (dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_load = 32'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model, built lane by lane
  function automatic int size_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int sz = size_bytes(f3);
    int base = int'(a[1:0]) / sz * sz;
    logic [3:0] r = 4'b0;
    for (int l = 0; l < 4; l++) if (l >= base && l < base + sz) r[l] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    int sz = size_bytes(f3);
    logic [31:0] r = 32'b0;
    for (int l = 0; l < 4; l++) r[8*l +: 8] = sd[8*(l % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    int sz = size_bytes(f3);
    int base = int'(a[1:0]) / sz * sz;
    logic [31:0] r = 32'b0;
    logic sgn;
    for (int l = 0; l < sz; l++) r[8*l +: 8] = rd[8*(base + l) +: 8];
    sgn = r[8*sz - 1] & ~f3[2];
    for (int l = sz; l < 4; l++) r[8*l +: 8] = {8{sgn}};
    return r;
  endfunction

  // driver: one access from its IDLE cycle through DONE; ack_at = ACCESS cycle
  // index (1-based) carrying the ack, 0 = never ack (expect a bus error)
  task automatic do_access(input string tag, input bit wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sd,
                           input logic [31:0] rd, input int ack_at);
    int stall_cnt = 0;
    int req_cnt = 0;
    int cyc = 1;
    bit got_done = 0;
    logic [31:0] e;
    mem_write_i  = wr;
    mem_read_i   = ~wr;
    funct3_i     = f3;
    alu_res_i    = addr;
    store_data_i = sd;
    if (wr) exp_q.push_back(last_load);
    else if (ack_at == 0) exp_q.push_back(32'b0);
    else exp_q.push_back(m_load(f3, addr, rd));

    @(negedge clk);
    check({tag, ".idle_stall"}, {31'b0, stall_o}, 32'd1);
    check({tag, ".idle_req"}, {31'b0, dmem_req_o}, 32'd0);
    check({tag, ".idle_done"}, {31'b0, done_o}, 32'd0);
    check({tag, ".idle_mis"}, {31'b0, misaligned_o}, 32'd0);
    stall_cnt++;
    tick();
    mem_write_i  = 1'b0;
    mem_read_i   = 1'b0;
    alu_res_i    = $urandom;
    store_data_i = $urandom;

    for (int c = 1; c <= TB_TIMEOUT + 4; c++) begin
      @(negedge clk);
      cyc++;
      if (done_o) begin
        got_done = 1;
        break;
      end
      req_cnt += dmem_req_o;
      stall_cnt += stall_o;
      if (c == 1 || c == ack_at) begin
        check({tag, ".req"}, {31'b0, dmem_req_o}, 32'd1);
        check({tag, ".addr"}, dmem_addr_o, {addr[31:2], 2'b00});
        check({tag, ".be"}, {28'b0, dmem_be_o}, {28'b0, m_be(f3, addr)});
        check({tag, ".we"}, {31'b0, dmem_we_o}, {31'b0, wr});
        if (wr) check({tag, ".wdata"}, dmem_wdata_o, m_wdata(f3, sd));
      end
      if (c == ack_at) begin
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = rd;
      end
      tick();
      dmem_ack_i   = 1'b0;
      dmem_rdata_i = $urandom;
    end

    if (!got_done) check({tag, ".done_seen"}, 32'd0, 32'd1);
    check({tag, ".req_cycles"}, req_cnt, (ack_at == 0) ? TB_TIMEOUT : ack_at);
    check({tag, ".stall_cycles"}, stall_cnt, req_cnt + 1);
    check({tag, ".done_cycle"}, cyc, req_cnt + 2);
    check({tag, ".done_stall"}, {31'b0, stall_o}, 32'd0);
    check({tag, ".done_req"}, {31'b0, dmem_req_o}, 32'd0);
    check({tag, ".bus_err"}, {31'b0, bus_err_o}, {31'b0, (ack_at == 0)});
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".load_data"}, load_data_o, e);
      last_load = e;
    end
    tick();
  endtask

  // no-access cases: misaligned and illegal requests
  task automatic do_reject(input string tag, input bit wr, input bit rd_req,
                           input logic [2:0] f3, input logic [31:0] addr, input bit exp_mis);
    mem_write_i  = wr;
    mem_read_i   = rd_req;
    funct3_i     = f3;
    alu_res_i    = addr;
    store_data_i = $urandom;
    @(negedge clk);
    check({tag, ".mis"}, {31'b0, misaligned_o}, {31'b0, exp_mis});
    check({tag, ".stall"}, {31'b0, stall_o}, 32'd0);
    check({tag, ".req"}, {31'b0, dmem_req_o}, 32'd0);
    tick();
    mem_write_i = 1'b0;
    mem_read_i  = 1'b0;
    @(negedge clk);
    check({tag, ".state"}, {30'b0, dbg_state_o}, 32'd0);
    check({tag, ".req_after"}, {31'b0, dmem_req_o}, 32'd0);
    check({tag, ".load_keep"}, load_data_o, last_load);
    tick();
  endtask

  initial begin
    logic [2:0] f3;
    logic [31:0] a;
    bit wr;
    rst_n        = 1'b0;
    mem_read_i   = 1'b0;
    mem_write_i  = 1'b0;
    funct3_i     = 3'b000;
    alu_res_i    = 32'b0;
    store_data_i = 32'b0;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'b0;
    tick();
    tick();
    @(negedge clk);
    check("rst.state", {30'b0, dbg_state_o}, 32'd0);
    check("rst.req", {31'b0, dmem_req_o}, 32'd0);
    check("rst.we", {31'b0, dmem_we_o}, 32'd0);
    check("rst.be", {28'b0, dmem_be_o}, 32'd0);
    check("rst.done", {31'b0, done_o}, 32'd0);
    check("rst.bus_err", {31'b0, bus_err_o}, 32'd0);
    check("rst.load", load_data_o, 32'd0);
    tick();
    rst_n = 1'b1;

    // request in the first cycle after reset release
    do_access("lb", 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1);
    do_access("sh", 1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 1);
    do_reject("lw_mis", 1'b0, 1'b1, 3'b010, 32'h0000_3001, 1'b1);
    do_reject("lh_mis", 1'b0, 1'b1, 3'b001, 32'h0000_3003, 1'b1);
    do_reject("ld_ill", 1'b0, 1'b1, 3'b011, 32'h0000_3000, 1'b0);
    do_reject("st_ill", 1'b1, 1'b0, 3'b100, 32'h0000_3000, 1'b0);
    do_reject("both_ill", 1'b1, 1'b1, 3'b101, 32'h0000_3000, 1'b0);
    do_access("lhu", 1'b0, 3'b101, 32'h0000_4000, 32'h0, 32'h0000_F00D, 5);
    do_access("lh_hi", 1'b0, 3'b001, 32'h0000_4002, 32'h0, 32'h8001_0000, 2);
    do_access("sb", 1'b1, 3'b000, 32'h0000_4001, 32'h1234_56A5, 32'h0, 3);
    do_access("lw_to", 1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'h0, 0);

    // reset during the second ACCESS cycle of a store, ack arriving afterwards
    mem_write_i  = 1'b1;
    funct3_i     = 3'b010;
    alu_res_i    = 32'h0000_6000;
    store_data_i = 32'hDEAD_BEEF;
    tick();
    mem_write_i = 1'b0;
    @(negedge clk);
    check("rst_acc.req1", {31'b0, dmem_req_o}, 32'd1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_acc.req2", {31'b0, dmem_req_o}, 32'd1);
    tick();
    rst_n        = 1'b1;
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h1111_1111;
    last_load    = 32'b0;
    @(negedge clk);
    check("rst_acc.req_off", {31'b0, dmem_req_o}, 32'd0);
    check("rst_acc.state", {30'b0, dbg_state_o}, 32'd0);
    check("rst_acc.done", {31'b0, done_o}, 32'd0);
    tick();
    dmem_ack_i = 1'b0;
    @(negedge clk);
    check("rst_acc.done2", {31'b0, done_o}, 32'd0);
    check("rst_acc.state2", {30'b0, dbg_state_o}, 32'd0);
    check("rst_acc.load", load_data_o, 32'd0);
    tick();

    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, wr ? 2 : 4))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
      a = $urandom;
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      do_access($sformatf("rnd%0d", i), wr, f3, a, $urandom, $urandom,
                $urandom_range(1, 4));
    end

    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port alu_res_i, input, 32 bits: effective byte address, taken from the execute-stage ALU result.
REQ-004 SHALL have port store_data_i, input, 32 bits: rs2 store data, right-aligned.
REQ-005 SHALL have ports mem_read_i and mem_write_i, input, 1 bit each: load/store request for the current instruction.
REQ-006 SHALL have port funct3_i, input, 3 bits: access size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 SHALL have port dmem_req_o, output, 1 bit: memory request.
REQ-008 SHALL have port dmem_we_o, output, 1 bit: write enable.
REQ-009 SHALL have ports dmem_addr_o (32 bits, word-aligned), dmem_wdata_o (32 bits) and dmem_be_o (4 bits), all outputs.
REQ-010 SHALL have ports dmem_ack_i (input, 1 bit) and dmem_rdata_i (input, 32 bits).
REQ-011 SHALL have port load_data_o, output, 32 bits: formatted load result.
REQ-012 SHALL have ports stall_o, done_o, misaligned_o and bus_err_o, outputs, 1 bit each.
REQ-013 SHALL have parameter TIMEOUT, default 255: maximum number of ACCESS cycles to wait for an ack.

Function
REQ-014 SHALL implement states IDLE, ACCESS and DONE.
REQ-015 Valid request SHALL mean: mem_read_i or mem_write_i is high, funct3_i is legal for the operation, and the address is aligned.
- Stores legal: 000, 001, 010.
- Loads legal: 000, 001, 010, 100, 101.
- mem_write_i has priority when both request inputs are high.
REQ-016 Illegal funct3_i SHALL be ignored: no access, no flag.
REQ-017 Alignment rules SHALL be:
- halfword requires addr[0]=0;
- word requires addr[1:0]=00.
REQ-018 On a misaligned request in IDLE, misaligned_o SHALL be high combinationally, with no memory access and no stall.
REQ-019 IDLE with a valid request:
- stall_o SHALL be high combinationally;
- address, formatted write data, byte enables, funct3 and we SHALL be latched;
- next state SHALL be ACCESS.
REQ-020 In ACCESS:
- dmem_req_o SHALL be 1 and stall_o SHALL be 1;
- dmem_addr_o, dmem_we_o, dmem_wdata_o and dmem_be_o SHALL hold the latched values, stable until ack;
- the timeout counter SHALL increment each cycle.
REQ-021 In ACCESS, dmem_ack_i SHALL only be sampled while dmem_req_o=1.
- On ack during a load, the formatted dmem_rdata_i SHALL be registered into load_data_o.
- On ack, next state SHALL be DONE.
REQ-022 If the counter reaches TIMEOUT without an ack:
- bus_err_o SHALL pulse for one cycle in DONE;
- load_data_o SHALL be set to 0;
- next state SHALL be DONE.
REQ-023 In DONE:
- done_o SHALL be 1 and stall_o SHALL be 0;
- request inputs SHALL be ignored;
- next state SHALL be IDLE unconditionally;
- minimum load/store latency SHALL therefore be 3 cycles: IDLE, ACCESS, DONE.
REQ-024 Store formatting SHALL be:
- SB: be = 0001 << addr[1:0], wdata = byte replicated x4;
- SH: be = 0011 << (2*addr[1]), wdata = halfword replicated x2;
- SW: be = 1111, wdata = store_data_i.
REQ-025 Load formatting SHALL be:
- select the byte by addr[1:0] or the halfword by addr[1] from dmem_rdata_i;
- LB/LH sign-extend, LBU/LHU zero-extend, LW pass through.
REQ-026 For loads, dmem_be_o SHALL equal the enables computed for the same size.
REQ-027 dmem_addr_o SHALL be {addr[31:2], 2'b00}.
REQ-028 load_data_o SHALL hold its value until the next load completes; stores SHALL not alter it.
REQ-029 Outside ACCESS, dmem_req_o and dmem_we_o SHALL be 0.
REQ-030 Outside DONE, done_o SHALL be 0.

Reset
REQ-031 With rst_n=0 at a rising edge, the block SHALL enter IDLE and clear to 0:
- counter, latched fields and load_data_o;
- dmem_req_o, dmem_we_o and dmem_be_o;
- done_o and bus_err_o.
REQ-032 Reset during ACCESS SHALL drop dmem_req_o at that edge; a late ack SHALL be ignored.
REQ-033 After reset release, a request SHALL be accepted on the first IDLE cycle.

Verification
REQ-034 LB at 0x1003, rdata 0x80FF_1234 with ack on the 1st ACCESS cycle -> dmem_addr_o 0x1000, be 1000, load_data_o 0xFFFF_FF80, done_o high in the 3rd cycle.
REQ-035 SH at 0x2002, store_data 0x0000_ABCD -> be 1100, wdata 0xABCD_ABCD, we=1, stall_o high for 2 cycles.
REQ-036 LW at 0x3001 -> misaligned_o=1, dmem_req_o=0, stall_o=0, load_data_o unchanged.
REQ-037 LHU at 0x4000 with ack delayed 5 cycles, rdata 0x0000_F00D -> req held with stable address, load_data_o 0x0000_F00D, stall_o high for 6 cycles.
REQ-038 LW with no ack and TIMEOUT=8 -> req high for 8 ACCESS cycles, then bus_err_o and done_o pulse together, load_data_o=0.
REQ-039 rst_n=0 in the 2nd ACCESS cycle of a SW, then ack one cycle later -> req=0 after the edge, state IDLE, no done_o.
